// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and shift-level split helpers for shifter_pipe
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    function automatic int lvl_per_stage(input int sw, input int pipe);
        return (sw + pipe - 1) / pipe;
    endfunction

    // Levels are consumed MSB-first; trailing stages may end up with no level at all.
    function automatic int stage_hi(input int s, input int sw, input int pipe);
        return sw - 1 - s * lvl_per_stage(sw, pipe);
    endfunction

    function automatic int stage_lo(input int s, input int sw, input int pipe);
        int lo;
        lo = stage_hi(s, sw, pipe) - lvl_per_stage(sw, pipe) + 1;
        return (lo < 0) ? 0 : lo;
    endfunction

    function automatic logic op_reserved(input logic [2:0] op);
        return op > 3'(OP_ROR);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - one registered group of barrel-shift levels LVL_HI..LVL_LO
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int W      = 32,
    parameter int SW     = 5,
    parameter int LVL_HI = 4,
    parameter int LVL_LO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W-1:0]  din,
    input  logic [2:0]    op_in,
    input  logic [SW-1:0] shamt_in,
    input  logic          cout_in,
    output logic [W-1:0]  dout,
    output logic [2:0]    op_out,
    output logic [SW-1:0] shamt_out,
    output logic          cout_out
);

    localparam int NL = (LVL_HI >= LVL_LO) ? LVL_HI - LVL_LO + 1 : 0;

    logic [W-1:0] d_last;
    logic         c_last;

    for (genvar i = 0; i < NL; i++) begin : g_lvl
        localparam int K  = LVL_HI - i;
        localparam int SH = 1 << K;

        logic [W-1:0] dp, dn;
        logic         cp, cn;

        if (i == 0) begin : g_first
            assign dp = din;
            assign cp = cout_in;
        end else begin : g_next
            assign dp = g_lvl[i-1].dn;
            assign cp = g_lvl[i-1].cn;
        end

        // The last bit shifted out by this level is what the full shift would drop last,
        // so each active level simply overwrites the carry candidate.
        // SRA keeps the captured sign in the MSB, so it doubles as the fill bit.
        always_comb begin
            dn = dp;
            cn = cp;
            if (shamt_in[K]) begin
                case (op_in)
                    OP_SLL: begin
                        dn = dp << SH;
                        cn = dp[W-SH];
                    end
                    OP_SRL: begin
                        dn = dp >> SH;
                        cn = dp[SH-1];
                    end
                    OP_SRA: begin
                        dn = $signed(dp) >>> SH;
                        cn = dp[SH-1];
                    end
                    OP_ROL:  dn = (dp << SH) | (dp >> (W - SH));
                    OP_ROR:  dn = (dp >> SH) | (dp << (W - SH));
                    default: dn = dp;
                endcase
            end
        end
    end

    if (NL == 0) begin : g_pass
        assign d_last = din;
        assign c_last = cout_in;
    end else begin : g_tail
        assign d_last = g_lvl[NL-1].dn;
        assign c_last = g_lvl[NL-1].cn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            op_out    <= '0;
            shamt_out <= '0;
            cout_out  <= 1'b0;
        end else if (en) begin
            dout      <= d_last;
            op_out    <= op_in;
            shamt_out <= shamt_in;
            cout_out  <= c_last;
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined barrel shifter/rotator with global-stall valid/ready handshake
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter  int W    = 32,
    parameter  int PIPE = 2,
    localparam int SW   = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    input  logic [2:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  dout,
    output logic          cout,
    output logic          zero,
    output logic          op_err
);

    logic            adv;
    logic [PIPE-1:0] vld;

    assign adv       = out_ready || !out_valid;
    assign in_ready  = adv;
    assign out_valid = vld[PIPE-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (adv) begin
            vld <= (vld << 1) | PIPE'(in_valid);
        end
    end

    for (genvar s = 0; s < PIPE; s++) begin : g_stg
        logic [W-1:0]  dp, dq;
        logic [2:0]    op_p, op_q;
        logic [SW-1:0] sp, sq;
        logic          cp, cq;

        if (s == 0) begin : g_first
            assign dp   = din;
            assign op_p = op;
            assign sp   = shamt;
            assign cp   = 1'b0;
        end else begin : g_next
            assign dp   = g_stg[s-1].dq;
            assign op_p = g_stg[s-1].op_q;
            assign sp   = g_stg[s-1].sq;
            assign cp   = g_stg[s-1].cq;
        end

        shifter_stage #(
            .W      (W),
            .SW     (SW),
            .LVL_HI (stage_hi(s, SW, PIPE)),
            .LVL_LO (stage_lo(s, SW, PIPE))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .din       (dp),
            .op_in     (op_p),
            .shamt_in  (sp),
            .cout_in   (cp),
            .dout      (dq),
            .op_out    (op_q),
            .shamt_out (sq),
            .cout_out  (cq)
        );
    end

    // Flags derive from the registered final stage, so they hold with dout during a stall.
    assign dout   = g_stg[PIPE-1].dq;
    assign cout   = g_stg[PIPE-1].cq & (|g_stg[PIPE-1].sq);
    assign zero   = out_valid && (dout == '0);
    assign op_err = out_valid && op_reserved(g_stg[PIPE-1].op_q);

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - directed and random checks of shifter_pipe at W=8/32/64
module tb_shifter_pipe;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] d;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] din;
    logic [5:0]  shamt;

    logic        r8, v8, c8, z8, e8;
    logic [7:0]  d8;
    logic        r32, v32, c32, z32, e32;
    logic [31:0] d32;
    logic        r64, v64, c64, z64, e64;
    logic [63:0] d64;

    logic [2:0]  o_r, o_v, o_c, o_z, o_e;
    logic [63:0] o_d [3];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    exp_t sbq[$];
    bit   sb_en    = 0;
    bit   acc32    = 0;
    bit   stalled  = 0;
    exp_t held;
    int   n_out[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    shifter_pipe #(.W(8), .PIPE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8), .din(din[7:0]),
        .shamt(shamt[2:0]), .op(op), .out_valid(v8), .out_ready(out_ready), .dout(d8),
        .cout(c8), .zero(z8), .op_err(e8));

    shifter_pipe #(.W(32), .PIPE(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .din(din[31:0]),
        .shamt(shamt[4:0]), .op(op), .out_valid(v32), .out_ready(out_ready), .dout(d32),
        .cout(c32), .zero(z32), .op_err(e32));

    shifter_pipe #(.W(64), .PIPE(6)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64), .din(din),
        .shamt(shamt), .op(op), .out_valid(v64), .out_ready(out_ready), .dout(d64),
        .cout(c64), .zero(z64), .op_err(e64));

    assign o_r = {r64, r32, r8};
    assign o_v = {v64, v32, v8};
    assign o_c = {c64, c32, c8};
    assign o_z = {z64, z32, z8};
    assign o_e = {e64, e32, e8};
    assign o_d[0] = {56'd0, d8};
    assign o_d[1] = {32'd0, d32};
    assign o_d[2] = d64;

    function automatic int wid(input int id);
        return (id == 0) ? 8 : ((id == 1) ? 32 : 64);
    endfunction

    // Bit-by-bit reference: result bit i is read from the source position the op maps it to.
    function automatic exp_t model(input int id, input logic [63:0] d_in, input logic [5:0] sh,
                                   input logic [2:0] o);
        exp_t        e;
        int          w, n;
        logic [63:0] d;
        w = wid(id);
        n = int'(sh) % w;
        d = (w == 64) ? d_in : (d_in & ((64'd1 << w) - 64'd1));
        e = '0;
        e.id = id[1:0];
        for (int i = 0; i < w; i++) begin
            case (o)
                3'd0: if (i >= n) e.d[i] = d[i-n];
                3'd1: if (i + n < w) e.d[i] = d[i+n];
                3'd2: if (i + n < w) e.d[i] = d[i+n]; else e.d[i] = d[w-1];
                3'd3: e.d[i] = d[(i - n + w) % w];
                3'd4: e.d[i] = d[(i + n) % w];
                default: e.d[i] = d[i];
            endcase
        end
        if (n != 0 && o == 3'd0) e.c = d[w-n];
        if (n != 0 && (o == 3'd1 || o == 3'd2)) e.c = d[n-1];
        e.z = (e.d == 64'd0);
        e.e = (o > 3'd4);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        int   k;
        @(negedge clk);
        if (sb_en) begin
            for (int i = 0; i < 3; i++) begin
                if (o_v[i] && out_ready) begin
                    k = -1;
                    for (int j = 0; j < sbq.size(); j++)
                        if (k < 0 && sbq[j].id == i[1:0]) k = j;
                    if (k < 0) begin
                        chk($sformatf("unexpected_beat_w%0d", wid(i)), 64'(o_v[i]), 64'd0);
                    end else begin
                        e = sbq[k];
                        sbq.delete(k);
                        chk($sformatf("dout_w%0d", wid(i)), o_d[i], e.d);
                        chk($sformatf("cout_w%0d", wid(i)), 64'(o_c[i]), 64'(e.c));
                        chk($sformatf("zero_w%0d", wid(i)), 64'(o_z[i]), 64'(e.z));
                        chk($sformatf("op_err_w%0d", wid(i)), 64'(o_e[i]), 64'(e.e));
                        n_out[i]++;
                    end
                end
                if (in_valid && o_r[i]) sbq.push_back(model(i, din, shamt, op));
            end
            if (stalled) begin
                chk("hold_valid", 64'(o_v[1]), 64'd1);
                chk("hold_dout", o_d[1], held.d);
                chk("hold_flags", {61'd0, o_c[1], o_z[1], o_e[1]}, {61'd0, held.c, held.z, held.e});
            end
            stalled = o_v[1] && !out_ready;
            held.d  = o_d[1];
            held.c  = o_c[1];
            held.z  = o_z[1];
            held.e  = o_e[1];
        end
        acc32 = in_valid && o_r[1];
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [63:0] d, input logic [5:0] s, input logic [2:0] o,
                         output int lat, output logic [63:0] rd, output logic [2:0] rf);
        din       = d;
        shamt     = s;
        op        = o;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!o_v[1] && lat < 20) begin
            step();
            lat++;
        end
        rd = o_d[1];
        rf = {o_c[1], o_z[1], o_e[1]};
        step();
    endtask

    initial begin
        int          lat, idx, base;
        logic [63:0] rd;
        logic [2:0]  rf;

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        op = 3'd0; din = 64'hFFFF_FFFF_FFFF_FFFF; shamt = 6'd3;
        step();
        chk("rst_valid", 64'(o_v[1]), 64'd0);
        chk("rst_dout", o_d[1], 64'd0);
        step();
        step();
        chk("rst_valid_all", 64'(o_v), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        sbq.delete();
        sb_en    = 1;
        step();
        chk("ready_after_rst", 64'(o_r[1]), 64'd1);

        send1(64'h8000_0001, 6'd4, 3'd2, lat, rd, rf);
        chk("sra_latency", 64'(lat), 64'd2);
        chk("sra_dout", rd, 64'hF800_0000);
        chk("sra_cout", 64'(rf[2]), 64'd0);
        send1(64'h8000_0001, 6'd4, 3'd1, lat, rd, rf);
        chk("srl_dout", rd, 64'h0800_0000);
        send1(64'h8000_0001, 6'd4, 3'd4, lat, rd, rf);
        chk("ror_dout", rd, 64'h1800_0000);

        send1(64'hC000_0000, 6'd1, 3'd0, lat, rd, rf);
        chk("sll1_dout", rd, 64'h8000_0000);
        chk("sll1_cout", 64'(rf[2]), 64'd1);
        send1(64'hC000_0000, 6'd2, 3'd0, lat, rd, rf);
        chk("sll2_dout", rd, 64'd0);
        chk("sll2_zero", 64'(rf[1]), 64'd1);
        chk("sll2_cout", 64'(rf[2]), 64'd1);

        idx  = 0;
        base = n_out[1];
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (idx < 8) begin
                if (!in_valid) begin
                    din   = {$urandom, $urandom};
                    shamt = 6'($urandom);
                    op    = 3'($urandom_range(0, 4));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (acc32) begin
                idx++;
                in_valid = 1'b0;
            end
        end
        chk("bp_sent", 64'(idx), 64'd8);
        chk("bp_received", 64'(n_out[1] - base), 64'd8);

        send1(64'h1234_5678, 6'd9, 3'd6, lat, rd, rf);
        chk("rsv_dout", rd, 64'h1234_5678);
        chk("rsv_op_err", 64'(rf[0]), 64'd1);
        chk("rsv_cout", 64'(rf[2]), 64'd0);
        send1(64'h1, 6'd31, 3'd3, lat, rd, rf);
        chk("rol31_dout", rd, 64'h8000_0000);
        chk("rol31_op_err", 64'(rf[0]), 64'd0);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        din = {$urandom, $urandom}; shamt = 6'd5; op = 3'd0;
        step();
        din = {$urandom, $urandom}; op = 3'd1;
        step();
        in_valid = 1'b0;
        sb_en    = 0;
        rst_n    = 1'b0;
        step();
        chk("midrst_valid", 64'(o_v), 64'd0);
        rst_n   = 1'b1;
        sbq.delete();
        stalled = 0;
        sb_en   = 1;
        step();
        chk("midrst_valid_after", 64'(o_v), 64'd0);

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            din       = {$urandom, $urandom};
            shamt     = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            op        = 3'($urandom_range(0, 7));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("drain_valid", 64'(o_v), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
